// File: rtl/rv32i_pkg.sv
// Shared types and constants for the rv32i memory sequencer.
package rv32i_pkg;

    // Sequencer phases for one instruction (plus the loader slot).
    typedef enum logic [2:0] {
        ST_BOUND   = 3'd0,
        ST_F_ISSUE = 3'd1,
        ST_F_WAIT  = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_D_ISSUE = 3'd4,
        ST_D_WAIT  = 3'd5,
        ST_COMMIT  = 3'd6,
        ST_LOAD    = 3'd7
    } seq_state_t;

    // addi x0,x0,0 -- presented to the core out of reset.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Legal RAM read latency range; the wait counter is sized for RD_LAT_MAX-1.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int LAT_CNT_W  = 2;

endpackage

// File: rtl/rv32i_lat_counter.sv
// Down-counter used to time RAM read latency for fetch and data reads.
module rv32i_lat_counter
    import rv32i_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [LAT_CNT_W-1:0] load_val,
    input  logic                 dec,
    output logic                 expired
);

    logic [LAT_CNT_W-1:0] cnt;

    // Load wins over decrement; the count saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/rv32i_mem_sequencer.sv
// Multi-cycle sequencer sharing one single-port synchronous RAM between
// instruction fetch, data access and a program loader for the rv32i core.
module rv32i_mem_sequencer
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1     // legal RD_LAT_MIN..RD_LAT_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] core_pc,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    input  logic              core_we,
    input  logic              core_dreq,
    output logic [31:0]       core_instr,
    output logic [31:0]       core_rdata,
    output logic              core_ce,
    input  logic              halt,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instret
);

    // Counter preload so that expiry lands on the cycle read data is valid.
    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RD_LAT - 1);

    seq_state_t state, state_nxt;
    logic       cnt_load, cnt_dec, cnt_expired;

    // Byte-lane bits and upper data-address bits are intentionally ignored.
    logic unused_ok;
    assign unused_ok = &{1'b0, core_addr[31:ADDR_W], core_addr[1:0],
                         core_pc[1:0], ld_addr[1:0]};

    rv32i_lat_counter u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LAT_INIT),
        .dec      (cnt_dec),
        .expired  (cnt_expired)
    );

    // Next-state and RAM/handshake strobes; all outputs are decoded from state.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        core_ce   = 1'b0;
        ld_ready  = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            ST_BOUND: begin
                if (ld_valid)
                    state_nxt = ST_LOAD;
                else if (!halt)
                    state_nxt = ST_F_ISSUE;
            end
            ST_LOAD: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = ld_addr[ADDR_W-1:2];
                mem_wdata = ld_wdata;
                ld_ready  = 1'b1;
                state_nxt = ST_BOUND;
            end
            ST_F_ISSUE: begin
                mem_en    = 1'b1;
                mem_addr  = core_pc[ADDR_W-1:2];
                cnt_load  = 1'b1;
                state_nxt = ST_F_WAIT;
            end
            ST_F_WAIT: begin
                if (cnt_expired)
                    state_nxt = ST_SETTLE;
                else
                    cnt_dec = 1'b1;
            end
            ST_SETTLE: begin
                state_nxt = core_dreq ? ST_D_ISSUE : ST_COMMIT;
            end
            ST_D_ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = core_we;
                mem_addr  = core_addr[ADDR_W-1:2];
                mem_wdata = core_wdata;
                if (core_we) begin
                    state_nxt = ST_COMMIT;
                end else begin
                    cnt_load  = 1'b1;
                    state_nxt = ST_D_WAIT;
                end
            end
            ST_D_WAIT: begin
                if (cnt_expired)
                    state_nxt = ST_COMMIT;
                else
                    cnt_dec = 1'b1;
            end
            ST_COMMIT: begin
                core_ce   = 1'b1;
                state_nxt = ST_BOUND;
            end
            default: state_nxt = ST_BOUND;
        endcase
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_BOUND;
        else
            state <= state_nxt;
    end

    // Capture fetched instruction and load data only when the wait expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_instr <= NOP_INSTR;
            core_rdata <= '0;
        end else begin
            if ((state == ST_F_WAIT) && cnt_expired)
                core_instr <= mem_rdata;
            if ((state == ST_D_WAIT) && cnt_expired)
                core_rdata <= mem_rdata;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            instret <= '0;
        else if (state == ST_COMMIT)
            instret <= instret + 32'd1;
    end

endmodule
